// File: rtl/lea_pkg.sv
// rtl/lea_pkg.sv - shared widths and sequencer state encoding for the LEA block datapath
package lea_pkg;

  localparam int LEA_BLK_W = 128;
  localparam int LEA_KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYREQ = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } lea_seq_state_t;

endpackage

// File: rtl/lea_round_sequencer_if.sv
// rtl/lea_round_sequencer_if.sv - block in/out, key-store and round-stage signals of the sequencer
interface lea_round_sequencer_if #(
  parameter int IDX_W = 6
);
  import lea_pkg::*;

  logic                 din_valid;
  logic                 din_ready;
  logic [LEA_BLK_W-1:0] din;
  logic                 abort;
  logic                 rk_req;
  logic [IDX_W-1:0]     rk_idx;
  logic                 rk_valid;
  logic [LEA_KEY_W-1:0] rk_data;
  logic [LEA_BLK_W-1:0] rnd_din;
  logic [LEA_KEY_W-1:0] rnd_key;
  logic [LEA_BLK_W-1:0] rnd_dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [LEA_BLK_W-1:0] dout;

  // slave: the sequencer itself; master: block source, key store, round stage and sink
  modport slave (
    input  din_valid, din, abort, rk_valid, rk_data, rnd_dout, dout_ready,
    output din_ready, rk_req, rk_idx, rnd_din, rnd_key, dout_valid, dout
  );

  modport master (
    output din_valid, din, abort, rk_valid, rk_data, rnd_dout, dout_ready,
    input  din_ready, rk_req, rk_idx, rnd_din, rnd_key, dout_valid, dout
  );

endinterface

// File: rtl/lea_round_ctr.sv
// rtl/lea_round_ctr.sv - round-key index down-counter with load, saturating decrement and zero flag
module lea_round_ctr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // saturate at zero so the index can never wrap past the last key
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lea_round_sequencer.sv
// rtl/lea_round_sequencer.sv - NR-round LEA decrypt controller, keys fetched in descending index order
module lea_round_sequencer
  import lea_pkg::*;
#(
  parameter int NR    = 24,
  parameter int IDX_W = $clog2(NR) + 1
) (
  input logic                  clk,
  input logic                  rst_n,
  lea_round_sequencer_if.slave bus
);

  localparam logic [1:0]       ST_IDLE   = IDLE;
  localparam logic [1:0]       ST_KEYREQ = KEYREQ;
  localparam logic [1:0]       ST_ROUND  = ROUND;
  localparam logic [1:0]       ST_DONE   = DONE;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NR - 1);

  logic [1:0]           fsm_q, fsm_d;
  logic [LEA_BLK_W-1:0] state_q, state_d;
  logic [LEA_KEY_W-1:0] key_q, key_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 ctr_load;
  logic                 ctr_dec;
  logic                 ctr_zero;
  logic [IDX_W-1:0]     idx;

  lea_round_ctr #(
    .W (IDX_W)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ctr_load),
    .load_val_i (IDX_LAST),
    .dec_i      (ctr_dec),
    .cnt_o      (idx),
    .zero_o     (ctr_zero)
  );

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    key_d    = key_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    // abort wins over every transition and freezes state/key as they are
    if (bus.abort && (fsm_q != ST_IDLE)) begin
      fsm_d = ST_IDLE;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (bus.din_valid) begin
            state_d  = bus.din;
            ctr_load = 1'b1;
            fsm_d    = ST_KEYREQ;
          end
        end
        ST_KEYREQ: begin
          if (bus.rk_valid) begin
            key_d = bus.rk_data;
            fsm_d = ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_d = bus.rnd_dout;
          if (ctr_zero) begin
            fsm_d = ST_DONE;
          end else begin
            ctr_dec = 1'b1;
            fsm_d   = ST_KEYREQ;
          end
        end
        ST_DONE: begin
          if (dout_valid_q && bus.dout_ready) begin
            fsm_d = ST_IDLE;
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
    // dout_valid is registered, so it rises on the second DONE cycle
    dout_valid_d = (fsm_q == ST_DONE) && (fsm_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= ST_IDLE;
      state_q      <= '0;
      key_q        <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      key_q        <= key_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.din_ready  = (fsm_q == ST_IDLE);
  assign bus.rk_req     = (fsm_q == ST_KEYREQ);
  assign bus.rk_idx     = idx;
  assign bus.rnd_din    = state_q;
  assign bus.rnd_key    = key_q;
  assign bus.dout       = state_q;
  assign bus.dout_valid = dout_valid_q;

endmodule
